hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It holds a register-write scoreboard for the E, M and W stages, compares it with the Tuse demands of the instruction in D, and decides between stalling and forwarding. It drives the PC/D freeze, the E-stage bubble, and the forwarding-mux selects for the D, E and M stages. It sits beside the Decode stage and receives the per-instruction Tuse/Tnew and register addresses that Decode produces.

## Interface
- TNEW_W, 2, width of Tnew field
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears the scoreboard and counter
- D_rs  in  5  instr[25:21] of the instruction in D
- D_rt  in  5  instr[20:16] of the instruction in D
- Rs_Tuse  in  2  0..2 = cycles until rs is needed; 3 = rs not read
- Rt_Tuse  in  2  same encoding for rt
- D_RegWreg  in  5  destination register of the D instruction
- D_Regwrite  in  1  D instruction writes the GRF
- D_Tnew  in  TNEW_W  cycles after entering E until the result exists (ALU 1, load 2, jal 0)
- stall  out  1  freeze the PC and the D pipeline register
- E_clear  out  1  load a bubble into the E pipeline register (equal to stall)
- D_fwd_rs, D_fwd_rt  out  2  0 = GRF, 1 = E result, 2 = M result
- E_fwd_rs, E_fwd_rt  out  2  0 = E register value, 1 = M result, 2 = W write data
- M_fwd_rt  out  1  0 = M register value, 1 = W write data
- stall_cnt  out  CNT_W  count of stall cycles, saturating

## Operation
- Scoreboard entries are E, M and W. Each entry holds {valid, waddr[4:0], tnew[1:0]}. E and M also hold rs and rt, and W holds rt only where it is needed.
- An entry "writes r" when valid, waddr==r, and r!=0. Register $0 never matches, never stalls and never forwards.
- Stall condition for rs: Rs_Tuse!=3, and either E writes rs with E.tnew>Rs_Tuse, or M writes rs with M.tnew>Rs_Tuse. The rt condition is the same with Rt_Tuse. stall = OR of the rs and rt conditions.
- D forwarding, when not stalling:
  - If E writes the register and E.tnew==0, select 1.
  - Else if M writes it and M.tnew==0, select 2.
  - Else select 0.
  - E has priority over M. W is covered by the GRF internal write-through.
- E forwarding: if M writes the register with M.tnew==0, select 1. Else if W writes it, select 2. Else select 0.
- M_fwd_rt = 1 when W writes M.rt.
- Each clock edge updates the scoreboard as follows:
  - W <= M.
  - M <= E, with tnew decremented and saturating at 0.
  - E <= stall ? bubble (valid 0, all fields 0) : {D_Regwrite, D_RegWreg, D_Tnew, D_rs, D_rt}.
  - When entering E, an instruction with D_Regwrite=0 is stored with valid=0.
- stall_cnt increments on every clock with stall=1 and saturates at all-ones.

## Timing
- All outputs except stall_cnt are combinational from the scoreboard and the D inputs, with zero latency. The scoreboard and stall_cnt update on the rising edge of clk.
- Reset value of every output is 0: no stall, all fwd selects 0, stall_cnt 0. Assertion of reset mid-stall clears the scoreboard immediately, so stall drops without waiting for a clock.
- Load-use: a load followed by a dependent ALU instruction (Tuse 1) stalls exactly 1 cycle. A load followed by a dependent branch (Tuse 0) stalls 2 cycles.
- If rs and rt both hit during a stall, stall_cnt still increments by 1 per cycle.
- D_rs==D_rt is legal. Both selects are then identical.
- Tnew saturation: an entry with tnew 0 stays 0 as it moves through M and W.

## Structure
- Package mips_hazard_pkg holds:
  - the Tuse/Tnew encodings, including TUSE_NONE=3;
  - the forwarding-select constants: FWD_GRF, FWD_E, FWD_M, FWD_W;
  - the scoreboard-entry struct typedef.
- One sub-module, hazard_sb_stage: a single scoreboard register with async reset, a bubble input and tnew decrement. It is instantiated three times.
- Match/compare logic stays in hazard_ctrl.

## Test plan
- After reset: lw $8 (Tnew 2), then add $9,$8,$1 (Rs_Tuse 1) -> stall=1 for 1 cycle. Next cycle stall=0 and E_fwd_rs=2 (W). stall_cnt=1.
- addu $3,$1,$2, then beq $3,$0 (Rs_Tuse 0) -> 1 stall cycle, then D_fwd_rs=2 (M, tnew 0).
- jal (waddr 31, Tnew 0), then jr $31 (Rs_Tuse 0) -> no stall, D_fwd_rs=1 (E).
- Write to $0 with Tnew 2, then a reader of $0 -> stall=0 and every select 0.
- addu $4 and addu $4 back to back, then a reader of $4 in E -> E_fwd_rs=1 (newest, M) beats W.
- Assert reset while a load-use stall is active -> stall falls asynchronously, stall_cnt=0, and the first instruction after release issues without stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and the scoreboard entry type for the MIPS hazard controller.
package mips_hazard_pkg;

  localparam int TNEW_BITS = 2;

  typedef logic [TNEW_BITS-1:0] tnew_t;
  typedef logic [1:0]           tuse_t;
  typedef logic [1:0]           fwd_t;

  localparam tuse_t TUSE_0    = 2'd0;
  localparam tuse_t TUSE_1    = 2'd1;
  localparam tuse_t TUSE_2    = 2'd2;
  localparam tuse_t TUSE_NONE = 2'd3;

  localparam tnew_t TNEW_JAL  = 2'd0;
  localparam tnew_t TNEW_ALU  = 2'd1;
  localparam tnew_t TNEW_LOAD = 2'd2;

  // D-stage selects use GRF/E/M; E-stage selects use reg/M/W, where M sits at 1.
  localparam fwd_t FWD_GRF  = 2'd0;
  localparam fwd_t FWD_E    = 2'd1;
  localparam fwd_t FWD_M    = 2'd2;
  localparam fwd_t FWD_W    = 2'd2;
  localparam fwd_t FWD_EX_M = 2'd1;

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    tnew_t      tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  function automatic logic writes_reg(sb_entry_t e, logic [4:0] r);
    return e.valid && (e.waddr == r) && (r != 5'd0);
  endfunction

  function automatic tnew_t tnew_dec(tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle: instruction register fields and Tuse/Tnew in, stall and forwarding selects out.
interface hazard_ctrl_if #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
);
  logic [4:0]        D_rs;
  logic [4:0]        D_rt;
  logic [1:0]        Rs_Tuse;
  logic [1:0]        Rt_Tuse;
  logic [4:0]        D_RegWreg;
  logic              D_Regwrite;
  logic [TNEW_W-1:0] D_Tnew;

  logic              stall;
  logic              E_clear;
  logic [1:0]        D_fwd_rs;
  logic [1:0]        D_fwd_rt;
  logic [1:0]        E_fwd_rs;
  logic [1:0]        E_fwd_rt;
  logic              M_fwd_rt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output D_rs, D_rt, Rs_Tuse, Rt_Tuse, D_RegWreg, D_Regwrite, D_Tnew,
    input  stall, E_clear, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, Rs_Tuse, Rt_Tuse, D_RegWreg, D_Regwrite, D_Tnew,
    output stall, E_clear, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_sb_stage.sv
// One scoreboard pipeline register: async clear, bubble insertion, optional saturating tnew decrement.
module hazard_sb_stage
  import mips_hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble,
  input  logic      dec,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
      if (dec) q.tnew <= tnew_dec(d.tnew);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward decision for the five-stage core, driven by an E/M/W register-write scoreboard.
module hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  sb_entry_t d_entry;
  sb_entry_t e_q;
  sb_entry_t m_q;
  sb_entry_t w_q;
  logic      stall;
  logic      stall_rs;
  logic      stall_rt;
  logic [CNT_W-1:0] cnt;

  function automatic logic stage_blocks(sb_entry_t e, logic [4:0] r, tuse_t tuse);
    return (tuse != TUSE_NONE) && writes_reg(e, r) && (e.tnew > tuse);
  endfunction

  function automatic fwd_t d_sel(sb_entry_t e, sb_entry_t m, logic [4:0] r);
    if (writes_reg(e, r) && e.tnew == '0) return FWD_E;
    else if (writes_reg(m, r) && m.tnew == '0) return FWD_M;
    else return FWD_GRF;
  endfunction

  function automatic fwd_t e_sel(sb_entry_t m, sb_entry_t w, logic [4:0] r);
    if (writes_reg(m, r) && m.tnew == '0) return FWD_EX_M;
    else if (writes_reg(w, r)) return FWD_W;
    else return FWD_GRF;
  endfunction

  always_comb begin
    d_entry       = '0;
    d_entry.valid = hz.D_Regwrite;
    d_entry.waddr = hz.D_RegWreg;
    d_entry.tnew  = tnew_t'(hz.D_Tnew);
    d_entry.rs    = hz.D_rs;
    d_entry.rt    = hz.D_rt;
  end

  // E takes a bubble on stall; only the E->M hop ages tnew.
  hazard_sb_stage u_sb_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .dec    (1'b0),
    .d      (d_entry),
    .q      (e_q)
  );

  hazard_sb_stage u_sb_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .d      (e_q),
    .q      (m_q)
  );

  hazard_sb_stage u_sb_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  always_comb begin
    stall_rs = stage_blocks(e_q, hz.D_rs, hz.Rs_Tuse) ||
               stage_blocks(m_q, hz.D_rs, hz.Rs_Tuse);
    stall_rt = stage_blocks(e_q, hz.D_rt, hz.Rt_Tuse) ||
               stage_blocks(m_q, hz.D_rt, hz.Rt_Tuse);
    stall    = stall_rs || stall_rt;
  end

  always_comb begin
    hz.stall    = stall;
    hz.E_clear  = stall;
    hz.D_fwd_rs = stall ? FWD_GRF : d_sel(e_q, m_q, hz.D_rs);
    hz.D_fwd_rt = stall ? FWD_GRF : d_sel(e_q, m_q, hz.D_rt);
    hz.E_fwd_rs = e_sel(m_q, w_q, e_q.rs);
    hz.E_fwd_rt = e_sel(m_q, w_q, e_q.rt);
    hz.M_fwd_rt = writes_reg(w_q, m_q.rt);
    hz.stall_cnt = cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (stall && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
